// File: rtl/if_stage_fifo.sv
// Instruction-fetch stage: credit-limited SRAM-like fetch, in-order instruction queue, redirect cancel.
// Optional IF_ADEF_EN: a misaligned fetch PC yields one address-error entry instead of a request.
`timescale 1ns/1ps
module if_stage_fifo #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs2ds_valid,
`ifdef IF_ADEF_EN
   output logic [64:0] fs2ds_bus,
`else
   output logic [63:0] fs2ds_bus,
`endif
   input  logic        ds_allowin,
   input  logic [32:0] br_zip
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_cancel;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_q_wptr;
   logic [PW-1:0] r_q_rptr;
   logic [PW-1:0] r_tag_wptr;
   logic [PW-1:0] r_tag_rptr;
   logic [31:0]   r_q_pc   [FIFO_DEPTH];
   logic [31:0]   r_q_inst [FIFO_DEPTH];
   logic [31:0]   r_tag    [FIFO_DEPTH];

   logic        w_br_taken;
   logic [31:0] w_br_target;
   logic        w_credit;
   logic        w_misaligned;
   logic        w_hs;
   logic        w_dok;
   logic        w_resp;
   logic        w_adef_push;
   logic        w_q_push;
   logic        w_q_pop;
   logic [31:0] w_push_pc;
   logic [31:0] w_push_inst;

   assign w_br_taken  = br_zip[32];
   assign w_br_target = br_zip[31:0];
   assign w_credit    = (SW'(r_inflight) + SW'(r_count)) < SW'(FIFO_DEPTH);

`ifdef IF_ADEF_EN
   logic                  r_adef_done;
   logic [FIFO_DEPTH-1:0] r_q_adef;

   assign w_misaligned = r_fetch_pc[1:0] != 2'b00;
   // One error entry per misaligned PC, issued once the pipe behind it has drained
   assign w_adef_push  = w_misaligned & ~r_adef_done & (r_inflight == '0)
                       & (r_count != DEPTH_C) & ~w_br_taken;
`else
   assign w_misaligned = 1'b0;
   assign w_adef_push  = 1'b0;
`endif

   assign inst_req    = ~reset & w_credit & (r_cancel == '0) & ~w_misaligned;
   assign inst_wr     = 1'b0;
   assign inst_size   = 2'b10;
   assign inst_addr   = r_fetch_pc;
   assign inst_wdata  = 32'h0;

   // Stale responses with nothing outstanding are ignored rather than corrupting counters
   assign w_hs        = inst_req & inst_addr_ok;
   assign w_dok       = inst_data_ok & ((r_cancel != '0) | (r_inflight != '0));
   assign w_resp      = w_dok & (r_cancel == '0);
   assign w_q_push    = w_resp | w_adef_push;
   assign w_q_pop     = fs2ds_valid & ds_allowin;
   assign w_push_pc   = w_adef_push ? r_fetch_pc : r_tag[r_tag_rptr];
   assign w_push_inst = w_adef_push ? 32'h0 : inst_rdata;

   assign fs2ds_valid = r_count != '0;
`ifdef IF_ADEF_EN
   assign fs2ds_bus   = {r_q_adef[r_q_rptr], r_q_pc[r_q_rptr], r_q_inst[r_q_rptr]};
`else
   assign fs2ds_bus   = {r_q_pc[r_q_rptr], r_q_inst[r_q_rptr]};
`endif

   // Control state; a redirect flushes both queues and converts all outstanding requests to cancels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_cancel   <= '0;
         r_count    <= '0;
         r_q_wptr   <= '0;
         r_q_rptr   <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else if (w_br_taken) begin
         r_fetch_pc <= w_br_target;
         r_cancel   <= r_cancel + r_inflight + CW'(w_hs) - CW'(w_dok);
         r_inflight <= '0;
         r_count    <= '0;
         r_q_wptr   <= '0;
         r_q_rptr   <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         if (w_hs) r_fetch_pc <= r_fetch_pc + 32'd4;
         r_cancel   <= r_cancel - CW'(w_dok & (r_cancel != '0));
         r_inflight <= r_inflight + CW'(w_hs) - CW'(w_resp);
         r_count    <= r_count + CW'(w_q_push) - CW'(w_q_pop);
         r_q_wptr   <= r_q_wptr + PW'(w_q_push);
         r_q_rptr   <= r_q_rptr + PW'(w_q_pop);
         r_tag_wptr <= r_tag_wptr + PW'(w_hs);
         r_tag_rptr <= r_tag_rptr + PW'(w_resp);
      end
   end

`ifdef IF_ADEF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_adef_done <= 1'b0;
      else if (w_br_taken) r_adef_done <= 1'b0;
      else if (w_adef_push) r_adef_done <= 1'b1;
   end
`endif

   // Queue and tag storage need no reset: validity lives in the counters
   always_ff @(posedge clk) begin
      if (w_q_push & ~w_br_taken) begin
         r_q_pc[r_q_wptr]   <= w_push_pc;
         r_q_inst[r_q_wptr] <= w_push_inst;
`ifdef IF_ADEF_EN
         r_q_adef[r_q_wptr] <= w_adef_push;
`endif
      end
      if (w_hs & ~w_br_taken) r_tag[r_tag_wptr] <= r_fetch_pc;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_q_push && !w_br_taken && r_count == DEPTH_C));
   a_no_tag_underflow: assert property (@(posedge clk) disable iff (reset)
      !(inst_data_ok && r_cancel == '0 && r_inflight == '0));

endmodule
